// File: rtl/cfu_c_requant.sv
// Requantizes Global Buffer C words (4 x int32 accumulators + bias) into packed int8 lanes.
// Build option: define REQUANT_SAT_STATS_EN to enable the clamped-lane counter on sat_count.
module cfu_c_requant #(
    parameter int LANES    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr,
    output logic                cfg_ready,
    input  logic [31:0]         cfg_mult,
    input  logic [5:0]          cfg_shift,
    input  logic [7:0]          cfg_offset,
    input  logic [7:0]          cfg_act_min,
    input  logic [7:0]          cfg_act_max,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*32-1:0] in_data,
    input  logic [LANES*32-1:0] in_bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*8-1:0]  out_data,
    output logic [CNT_BITS-1:0] out_count,
    output logic [CNT_BITS-1:0] sat_count
);
    localparam int DATA_W = 32;
    localparam int COEF_W = 32;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int RND_W  = PROD_W + 1;
    localparam int VAL_W  = PROD_W + 2;

    logic signed [COEF_W-1:0] mult_q;
    logic        [5:0]        shift_q;
    logic signed [7:0]        offset_q;
    logic signed [7:0]        act_min_q;
    logic signed [7:0]        act_max_q;

    logic                     advance;
    logic                     vld_p0;
    logic                     vld_p1;
    logic                     vld_p2;
    logic signed [DATA_W-1:0] acc_p0  [LANES];
    logic signed [PROD_W-1:0] prod_p1 [LANES];
    logic [LANES*8-1:0]       out_data_p2;

    logic signed [DATA_W-1:0] acc_d  [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [VAL_W-1:0]  val_d  [LANES];
    logic [LANES*8-1:0]       pack_d;

    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        logic signed [PROD_W-1:0] a_x;
        logic signed [PROD_W-1:0] b_x;
        a_x = {{COEF_W{a[DATA_W-1]}}, a};
        b_x = {{DATA_W{b[COEF_W-1]}}, b};
        return a_x * b_x;
    endfunction

    // One extra bit keeps prod + 2^(sh-1) from overflowing; rounds half toward +inf.
    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] prod,
        input logic        [5:0]        sh
    );
        logic signed [RND_W-1:0] wide;
        logic signed [RND_W-1:0] half;
        wide = {prod[PROD_W-1], prod};
        if (sh == 6'd0) begin
            return wide;
        end
        half = RND_W'(1) << (sh - 6'd1);
        return (wide + half) >>> sh;
    endfunction

    function automatic logic signed [VAL_W-1:0] add_offset(
        input logic signed [RND_W-1:0] r,
        input logic signed [7:0]       off
    );
        return {r[RND_W-1], r} + {{(VAL_W-8){off[7]}}, off};
    endfunction

    // Lower bound first, then upper bound, so an inverted range yields act_max.
    function automatic logic [7:0] clamp_i8(
        input logic signed [VAL_W-1:0] v,
        input logic signed [7:0]       lo,
        input logic signed [7:0]       hi
    );
        logic signed [VAL_W-1:0] lo_x;
        logic signed [VAL_W-1:0] hi_x;
        logic signed [VAL_W-1:0] x;
        lo_x = {{(VAL_W-8){lo[7]}}, lo};
        hi_x = {{(VAL_W-8){hi[7]}}, hi};
        x    = (v < lo_x) ? lo_x : v;
        x    = (x > hi_x) ? hi_x : x;
        return x[7:0];
    endfunction

    assign advance   = !vld_p2 || out_ready;
    assign in_ready  = advance;
    assign cfg_ready = !(vld_p0 || vld_p1 || vld_p2);
    assign out_valid = vld_p2;
    assign out_data  = out_data_p2;

    always_comb begin
        pack_d = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i]         = in_data[i*DATA_W +: DATA_W] + in_bias[i*DATA_W +: DATA_W];
            prod_d[i]        = mul_full(acc_p0[i], mult_q);
            val_d[i]         = add_offset(round_shift(prod_p1[i], shift_q), offset_q);
            pack_d[i*8 +: 8] = clamp_i8(val_d[i], act_min_q, act_max_q);
        end
    end

    // p0: bias-added accumulators; p1: full 64-bit products
    always_ff @(posedge clk) begin
        if (advance) begin
            acc_p0  <= acc_d;
            prod_p1 <= prod_d;
        end
    end

    // p2: packed int8 result register, valids, config and word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_data_p2 <= '0;
            out_count   <= '0;
            mult_q      <= 32'h4000_0000;
            shift_q     <= 6'd31;
            offset_q    <= 8'h00;
            act_min_q   <= 8'h80;
            act_max_q   <= 8'h7F;
        end else begin
            if (cfg_wr && cfg_ready) begin
                mult_q    <= cfg_mult;
                shift_q   <= cfg_shift;
                offset_q  <= cfg_offset;
                act_min_q <= cfg_act_min;
                act_max_q <= cfg_act_max;
                out_count <= '0;
            end else if (vld_p2 && out_ready) begin
                out_count <= out_count + CNT_BITS'(1);
            end
            if (advance) begin
                vld_p0 <= in_valid;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    out_data_p2 <= pack_d;
                end
            end
        end
    end

`ifdef REQUANT_SAT_STATS_EN
    localparam int SAT_W = $clog2(LANES + 1);

    logic [SAT_W-1:0]  sat_d;
    logic [SAT_W-1:0]  sat_p2;
    logic [CNT_BITS:0] sat_sum;

    function automatic logic out_of_range(
        input logic signed [VAL_W-1:0] v,
        input logic signed [7:0]       lo,
        input logic signed [7:0]       hi
    );
        logic signed [VAL_W-1:0] lo_x;
        logic signed [VAL_W-1:0] hi_x;
        lo_x = {{(VAL_W-8){lo[7]}}, lo};
        hi_x = {{(VAL_W-8){hi[7]}}, hi};
        return (v < lo_x) || (v > hi_x);
    endfunction

    always_comb begin
        sat_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_of_range(val_d[i], act_min_q, act_max_q)) begin
                sat_d = sat_d + SAT_W'(1);
            end
        end
    end

    assign sat_sum = {1'b0, sat_count} + (CNT_BITS+1)'(sat_p2);

    // Lane count travels with the word in p2 and is added only when the word is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_p2    <= '0;
            sat_count <= '0;
        end else begin
            if (advance && vld_p1) begin
                sat_p2 <= sat_d;
            end
            if (cfg_wr && cfg_ready) begin
                sat_count <= '0;
            end else if (vld_p2 && out_ready) begin
                sat_count <= sat_sum[CNT_BITS] ? '1 : sat_sum[CNT_BITS-1:0];
            end
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_cfu_c_requant.sv
// Self-checking bench for cfu_c_requant: vector table, scoreboard, stall/config/reset sequences.
`timescale 1ns/1ps
module tb_cfu_c_requant;
    localparam int CNT_BITS = 16;
`ifdef REQUANT_SAT_STATS_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_wr;
    logic                cfg_ready;
    logic [31:0]         cfg_mult;
    logic [5:0]          cfg_shift;
    logic [7:0]          cfg_offset;
    logic [7:0]          cfg_act_min;
    logic [7:0]          cfg_act_max;
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        in_data;
    logic [127:0]        in_bias;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic [CNT_BITS-1:0] out_count;
    logic [CNT_BITS-1:0] sat_count;

    always #5 clk = ~clk;

    cfu_c_requant #(.LANES(4), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ready(cfg_ready),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_offset(cfg_offset),
        .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .sat_count(sat_count)
    );

    typedef struct {
        logic [127:0] d;
        logic [127:0] b;
        logic [31:0]  exp;
        int           sat;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    logic [31:0] sb[$];
    logic [31:0] m_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [127:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] sat_exp(input int n);
        return SAT_EN ? 32'(n) : 32'd0;
    endfunction

    // Scoreboard: every delivered word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%08h want none", out_data);
            end else begin
                m_exp = sb.pop_front();
                check("out_data", out_data, m_exp);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [127:0] d, input logic [127:0] b, input logic [31:0] exp,
                        input bit push);
        int n;
        in_data  = d;
        in_bias  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) timeout("send_in_ready");
        else if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !cfg_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || !cfg_ready) timeout("drain");
    endtask

    task automatic set_cfg(input logic [31:0] m, input logic [5:0] s, input logic [7:0] o,
                           input logic [7:0] lo, input logic [7:0] hi);
        cfg_mult    = m;
        cfg_shift   = s;
        cfg_offset  = o;
        cfg_act_min = lo;
        cfg_act_max = hi;
        cfg_wr      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   lat;
        int   n0;
        int   sat_total;

        tbl[0] = '{lanes(100, 3, -3, 0),            lanes(0, 0, 0, 0),     32'h00FF0232, 0};
        tbl[1] = '{lanes(1000, -1000, 254, 256),    lanes(0, 0, 0, 0),     32'h7F7F807F, 3};
        tbl[2] = '{lanes(10, -10, 7, -7),           lanes(20, -20, -7, 7), 32'h0000F10F, 0};
        tbl[3] = '{lanes(32'h7FFFFFFF, -1, 255, -257), lanes(1, 0, 0, 0),  32'h807F0080, 2};
        tbl[4] = '{lanes(-256, -258, 1, -1),        lanes(0, 0, 0, 0),     32'h00018080, 1};

        reset = 1'b1;
        cfg_wr = 1'b0;
        cfg_mult = '0;
        cfg_shift = '0;
        cfg_offset = '0;
        cfg_act_min = '0;
        cfg_act_max = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_bias = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Latency with default config: out_valid after the third edge counting the accept edge
        in_data  = lanes(100, 3, -3, 0);
        in_bias  = '0;
        in_valid = 1'b1;
        sb.push_back(32'h00FF0232);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        drain();
        check("count_first", 32'(out_count), 32'd1);

        sat_total = 0;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d, tbl[i].b, tbl[i].exp, 1'b1);
            sat_total += tbl[i].sat;
        end
        drain();
        check("count_table", 32'(out_count), 32'd6);
        check("sat_table", 32'(sat_count), sat_exp(sat_total));

        // Config written on the same edge as an input word: the word uses the new config
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        set_cfg(32'd1, 6'd0, 8'h80, 8'h80, 8'h7F);
        send(lanes(0, 0, 0, 0), lanes(5, 0, 0, 0), 32'h80808085, 1'b1);
        cfg_wr = 1'b0;
        check("count_cleared", 32'(out_count), 32'd0);
        check("sat_cleared", 32'(sat_count), 32'd0);
        drain();
        check("count_cfg", 32'(out_count), 32'd1);
        check("sat_cfg", 32'(sat_count), 32'd0);

        set_cfg(32'd1, 6'd1, 8'h00, 8'h80, 8'h7F);
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        send(lanes(-3, 3, -1, 1), '0, 32'h010002FF, 1'b1);
        drain();

        set_cfg(32'd1, 6'd0, 8'h00, 8'd10, 8'hF6);
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        send(lanes(0, 100, -100, 5), '0, 32'hF6F6F6F6, 1'b1);
        drain();
        check("sat_inverted", 32'(sat_count), sat_exp(4));

        // Backpressure: 8 streamed words with a 5-cycle output stall in the middle
        set_cfg(32'h4000_0000, 6'd31, 8'h00, 8'h80, 8'h7F);
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        check("count_bp_clear", 32'(out_count), 32'd0);
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send(lanes(2 * k, -2 * k, 2 * k + 1, 0), '0,
                         {8'h00, 8'(k + 1), 8'(-k), 8'(k)}, 1'b1);
                end
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                if (!out_valid) timeout("bp_first_out");
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 32'(n_out - n0), 32'd8);
        check("count_bp", 32'(out_count), 32'd8);

        // cfg_wr while two words are in flight must be ignored
        send(lanes(20, -20, 40, 1), '0, 32'h0114F60A, 1'b1);
        send(lanes(6, 0, 0, 0), '0, 32'h00000003, 1'b1);
        set_cfg(32'h4000_0000, 6'd31, 8'd50, 8'h80, 8'h7F);
        @(negedge clk);
        check("cfg_ready_busy", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        drain();
        check("count_after_ignored", 32'(out_count), 32'd10);
        send(lanes(20, -20, 40, 1), '0, 32'h0114F60A, 1'b1);
        drain();
        check("count_old_cfg", 32'(out_count), 32'd11);

        // Reset with three words in flight: nothing emitted afterwards
        out_ready = 1'b0;
        n0 = n_out;
        for (int k = 0; k < 3; k++) begin
            send(lanes(k, k, k, k), '0, 32'd0, 1'b0);
        end
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_cfg_ready", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_out_count", 32'(out_count), 32'd0);
        check("rst2_cfg_ready", 32'(cfg_ready), 32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst2_no_stale", 32'(n_out - n0), 32'd0);
        send(lanes(100, 3, -3, 0), '0, 32'h00FF0232, 1'b1);
        drain();
        check("rst2_count", 32'(out_count), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
